invader_march_ctrl: RTL and testbench
=====================================

INVADER_MARCH_CTRL -- requirements
Module: invader_march_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  COLS, 8, formation columns; COL_PITCH, 60, column pitch in pixels; SPRITE_W, 50, sprite width in pixels.
  START_X, 80, initial formation origin x; START_Y, 40, initial formation origin y; X_STEP, 4, horizontal step in pixels.
  Y_STEP, 16, descent step in pixels; SCREEN_R, 640, right screen limit (exclusive); ROW_SPAN, 200, formation height in pixels.
  FLOOR_Y, 420, landing line; BASE_PERIOD, 30, frames per step; MIN_PERIOD, 2, fastest step period.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  frame_clk, in, 1, clock, one edge per video frame.
  Reset, in, 1, synchronous active-high reset.
  start, in, 1, begin march from IDLE.
  pause, in, 1, freeze step timer.
  col_alive, in, COLS, column has at least one live enemy.
  enemies_left, in, 6, live enemy count.
  form_x, out, 10, formation origin x.
  form_y, out, 10, formation origin y.
  enemy_direction_X, out, 1, 0 = left, 1 = right.
  enemy_direction_Y, out, 1, 1 = descending this step.
  step_pulse, out, 1, one-cycle pulse on each move.
  landed, out, 1, formation reached the floor.
  cleared, out, 1, all columns dead.
REQ-003 Reset SHALL be Reset, synchronous, active-high; the clock SHALL be frame_clk.

Function
REQ-004 The FSM SHALL have states IDLE, MARCH, DESCEND, LANDED and CLEARED.
REQ-005 IDLE -> MARCH SHALL occur on start=1; the step timer SHALL clear to 0 on entry to MARCH.
REQ-006 In MARCH with pause=0, the timer SHALL increment each cycle; when timer == period-1, a step SHALL occur and the timer SHALL return to 0.
REQ-007 With pause=1, the timer SHALL hold and no step SHALL occur; pause SHALL take priority over a due step.
REQ-008 Edges SHALL be computed from the lowest alive column Lc and the highest alive column Rc: left_edge = form_x + Lc*COL_PITCH; right_edge = form_x + Rc*COL_PITCH + SPRITE_W; arithmetic SHALL be 11-bit to avoid wrap.
REQ-009 On a step moving right: if right_edge + X_STEP <= SCREEN_R, form_x SHALL increase by X_STEP; otherwise the FSM SHALL enter DESCEND.
REQ-010 On a step moving left: if left_edge >= X_STEP, form_x SHALL decrease by X_STEP; otherwise the FSM SHALL enter DESCEND.
REQ-011 DESCEND SHALL last exactly one cycle, in which:
  - form_y SHALL increase by Y_STEP;
  - enemy_direction_X SHALL toggle;
  - enemy_direction_Y SHALL be 1 (0 in all other states);
  - step_pulse SHALL be 1.
REQ-012 After DESCEND, the FSM SHALL go to LANDED if form_y + ROW_SPAN >= FLOOR_Y, else back to MARCH.
REQ-013 step_pulse SHALL be 1 for exactly one cycle per horizontal move and per DESCEND cycle; a boundary-triggered step SHALL produce only the DESCEND pulse.
REQ-014 If col_alive == 0 in MARCH or DESCEND, the FSM SHALL enter CLEARED the next cycle, taking priority over any step.
REQ-015 LANDED and CLEARED SHALL be terminal until Reset; landed and cleared SHALL be 1 in their respective states.
REQ-016 The period SHALL be sampled only when the timer is 0; a change to enemies_left mid-count SHALL not affect the count in progress.

Reset
REQ-017 Reset SHALL set the following, overriding all other inputs:
  - state = IDLE, timer = 0;
  - form_x = START_X, form_y = START_Y;
  - enemy_direction_X = 1, enemy_direction_Y = 0;
  - step_pulse = 0, landed = 0, cleared = 0.
REQ-018 Reset asserted mid-march or in a terminal state SHALL take effect on the next frame_clk edge; start SHALL be ignored in the reset cycle.

Configuration
REQ-019 With the macro MARCH_SPEEDUP_EN defined, period SHALL be max(MIN_PERIOD, enemies_left).
REQ-020 With MARCH_SPEEDUP_EN undefined, period SHALL be BASE_PERIOD and enemies_left SHALL be unused.

Structure
REQ-021 Package invader_pkg SHALL hold:
  - the march state enum;
  - screen constants (SCREEN_R, FLOOR_Y);
  - default step and geometry constants.
REQ-022 Sub-module invader_edge_finder SHALL be a combinational priority encoder producing Lc, Rc and any_alive from col_alive.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - All columns alive, speedup off, start: first step at frame 30 gives form_x=84; after 22 steps form_x=168; the 23rd step gives DESCEND with form_y=56 and enemy_direction_X=0.
  - col_alive=8'b0000_0001 marching right: descent occurs only when form_x+50+4 > 640.
  - Repeated descents from form_y=40: the 12th descent reaches form_y=232; landed=1 and step_pulse stops.
  - pause held for 10 frames at timer=15: the step is delayed by exactly 10 frames.
  - col_alive drops to 0 in the cycle a step is due: cleared=1, form_x unchanged.
  - Speedup on, enemies_left=1: period=2; Reset mid-march restores form_x=80, form_y=40, state IDLE.

Source files
------------

// File: rtl/invader_pkg.sv
// rtl/invader_pkg.sv - march state enum, screen limits and default formation geometry.
package invader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MARCH,
      DESCEND,
      LANDED,
      CLEARED
   } march_state_e;

   localparam int SCREEN_R = 640;
   localparam int FLOOR_Y  = 420;

   localparam int DEF_COLS        = 8;
   localparam int DEF_COL_PITCH   = 60;
   localparam int DEF_SPRITE_W    = 50;
   localparam int DEF_START_X     = 80;
   localparam int DEF_START_Y     = 40;
   localparam int DEF_X_STEP      = 4;
   localparam int DEF_Y_STEP      = 16;
   localparam int DEF_ROW_SPAN    = 200;
   localparam int DEF_BASE_PERIOD = 30;
   localparam int DEF_MIN_PERIOD  = 2;

   localparam int TIMER_W = 8;

   function automatic int col_idx_w(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

endpackage

// File: rtl/invader_edge_finder.sv
// rtl/invader_edge_finder.sv - lowest/highest alive column priority encoder.
module invader_edge_finder
   import invader_pkg::*;
#(
   parameter int COLS = DEF_COLS
) (
   input  logic [COLS-1:0]            col_alive_i,
   output logic [col_idx_w(COLS)-1:0] lc_o,
   output logic [col_idx_w(COLS)-1:0] rc_o,
   output logic                       any_alive_o
);

   localparam int CW = col_idx_w(COLS);

   // Scan order makes the last hit win: downward for the lowest, upward for the highest.
   always_comb begin
      lc_o = '0;
      rc_o = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (col_alive_i[i]) lc_o = CW'(i);
      end
      for (int i = 0; i < COLS; i++) begin
         if (col_alive_i[i]) rc_o = CW'(i);
      end
   end

   assign any_alive_o = |col_alive_i;

endmodule

// File: rtl/invader_march_ctrl.sv
// rtl/invader_march_ctrl.sv - formation march/descend controller, one step per period of frames.
// Define MARCH_SPEEDUP_EN to derive the step period from enemies_left.
module invader_march_ctrl #(
   parameter int COLS        = invader_pkg::DEF_COLS,
   parameter int COL_PITCH   = invader_pkg::DEF_COL_PITCH,
   parameter int SPRITE_W    = invader_pkg::DEF_SPRITE_W,
   parameter int START_X     = invader_pkg::DEF_START_X,
   parameter int START_Y     = invader_pkg::DEF_START_Y,
   parameter int X_STEP      = invader_pkg::DEF_X_STEP,
   parameter int Y_STEP      = invader_pkg::DEF_Y_STEP,
   parameter int SCREEN_R    = invader_pkg::SCREEN_R,
   parameter int ROW_SPAN    = invader_pkg::DEF_ROW_SPAN,
   parameter int FLOOR_Y     = invader_pkg::FLOOR_Y,
   parameter int BASE_PERIOD = invader_pkg::DEF_BASE_PERIOD,
   parameter int MIN_PERIOD  = invader_pkg::DEF_MIN_PERIOD
) (
   input  logic            frame_clk,
   input  logic            Reset,
   input  logic            start,
   input  logic            pause,
   input  logic [COLS-1:0] col_alive,
   input  logic [5:0]      enemies_left,
   output logic [9:0]      form_x,
   output logic [9:0]      form_y,
   output logic            enemy_direction_X,
   output logic            enemy_direction_Y,
   output logic            step_pulse,
   output logic            landed,
   output logic            cleared
);

   import invader_pkg::*;

   localparam int CW = col_idx_w(COLS);

   march_state_e        state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [TIMER_W-1:0]  period_q, period_d;
   logic [TIMER_W-1:0]  period_cur, period_eff;
   logic [9:0]          form_x_q, form_x_d;
   logic [9:0]          form_y_q, form_y_d;
   logic                dir_x_q, dir_x_d;
   logic                pulse_q, pulse_d;

   logic [CW-1:0]       lc, rc;
   logic                any_alive;
   logic [10:0]         left_edge, right_edge;
   logic                step_due, can_move;

   invader_edge_finder #(
      .COLS (COLS)
   ) u_edge_finder (
      .col_alive_i (col_alive),
      .lc_o        (lc),
      .rc_o        (rc),
      .any_alive_o (any_alive)
   );

`ifdef MARCH_SPEEDUP_EN
   logic unused_cfg;
   assign unused_cfg = ^TIMER_W'(BASE_PERIOD);
   assign period_cur = (TIMER_W'(enemies_left) > TIMER_W'(MIN_PERIOD)) ?
                       TIMER_W'(enemies_left) : TIMER_W'(MIN_PERIOD);
`else
   logic unused_cfg;
   assign unused_cfg = ^{enemies_left, TIMER_W'(MIN_PERIOD)};
   assign period_cur = TIMER_W'(BASE_PERIOD);
`endif

   // A count in progress keeps the period latched at its timer==0 cycle.
   assign period_eff = (timer_q == '0) ? period_cur : period_q;
   assign step_due   = (timer_q == period_eff - TIMER_W'(1));

   assign left_edge  = 11'(form_x_q) + 11'(lc) * 11'(COL_PITCH);
   assign right_edge = 11'(form_x_q) + 11'(rc) * 11'(COL_PITCH) + 11'(SPRITE_W);
   assign can_move   = dir_x_q ? (right_edge + 11'(X_STEP) <= 11'(SCREEN_R))
                               : (left_edge >= 11'(X_STEP));

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         period_q <= '0;
         form_x_q <= 10'(START_X);
         form_y_q <= 10'(START_Y);
         dir_x_q  <= 1'b1;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         period_q <= period_d;
         form_x_q <= form_x_d;
         form_y_q <= form_y_d;
         dir_x_q  <= dir_x_d;
         pulse_q  <= pulse_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      period_d = period_q;
      form_x_d = form_x_q;
      form_y_d = form_y_q;
      dir_x_d  = dir_x_q;
      pulse_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MARCH;
               timer_d = '0;
            end
         end
         MARCH: begin
            if (!any_alive) begin
               state_d = CLEARED;
            end else if (!pause) begin
               if (timer_q == '0) period_d = period_cur;
               if (step_due) begin
                  timer_d = '0;
                  pulse_d = 1'b1;
                  if (can_move) begin
                     form_x_d = dir_x_q ? form_x_q + 10'(X_STEP) : form_x_q - 10'(X_STEP);
                  end else begin
                     // The descent is applied on entry so DESCEND shows the new row and heading.
                     state_d  = DESCEND;
                     form_y_d = form_y_q + 10'(Y_STEP);
                     dir_x_d  = ~dir_x_q;
                  end
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
         end
         DESCEND: begin
            timer_d = '0;
            if (!any_alive) begin
               state_d = CLEARED;
            end else if (11'(form_y_q) + 11'(ROW_SPAN) >= 11'(FLOOR_Y)) begin
               state_d = LANDED;
            end else begin
               state_d = MARCH;
            end
         end
         default: ;
      endcase
   end

   assign form_x            = form_x_q;
   assign form_y            = form_y_q;
   assign enemy_direction_X = dir_x_q;
   assign enemy_direction_Y = (state_q == DESCEND);
   assign step_pulse        = pulse_q;
   assign landed            = (state_q == LANDED);
   assign cleared           = (state_q == CLEARED);

endmodule

// File: tb/tb_invader_march_ctrl.sv
// tb/tb_invader_march_ctrl.sv - directed self-checking bench for invader_march_ctrl.
module tb_invader_march_ctrl;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] col_alive = 8'hFF;
   logic [5:0] enemies_left = 6'd30;
   logic [9:0] form_x, form_y;
   logic       enemy_direction_X, enemy_direction_Y, step_pulse, landed, cleared;

   int checks = 0;
   int errors = 0;

   invader_march_ctrl dut (
      .frame_clk         (frame_clk),
      .Reset             (Reset),
      .start             (start),
      .pause             (pause),
      .col_alive         (col_alive),
      .enemies_left      (enemies_left),
      .form_x            (form_x),
      .form_y            (form_y),
      .enemy_direction_X (enemy_direction_X),
      .enemy_direction_Y (enemy_direction_Y),
      .step_pulse        (step_pulse),
      .landed            (landed),
      .cleared           (cleared)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge frame_clk);
         #1;
      end
   endtask

   // Returns the number of edges until the next pulse (descent pulses only if asked), -1 on timeout.
   task automatic wait_move(input bit descent_only, input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (step_pulse && (!descent_only || enemy_direction_Y)) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (step_pulse) cnt++;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      start = 1'b1;
      pause = 1'b0;
      tick(2);
      Reset = 1'b0;
      start = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c, c2, hsteps;

      // Reset state, start held during reset must be ignored.
      do_reset();
      check("rst_form_x", form_x, 80);
      check("rst_form_y", form_y, 40);
      check("rst_dir_x", enemy_direction_X, 1);
      check("rst_dir_y", enemy_direction_Y, 0);
      check("rst_pulse", step_pulse, 0);
      check("rst_landed", landed, 0);
      check("rst_cleared", cleared, 0);
      count_pulses(35, c);
      check("idle_no_step", c, 0);
      check("idle_form_x", form_x, 80);

      // Full formation: 22 right steps then a descent.
      do_start();
      wait_move(0, 100, n);
      check("first_step_frame", n, 30);
      check("first_step_x", form_x, 84);
      for (int s = 2; s <= 22; s++) begin
         wait_move(0, 100, n);
         check("step_period", n, 30);
      end
      check("after22_x", form_x, 168);
      check("after22_y", form_y, 40);
      wait_move(0, 100, n);
      check("step23_frame", n, 30);
      check("desc1_dir_y", enemy_direction_Y, 1);
      check("desc1_y", form_y, 56);
      check("desc1_dir_x", enemy_direction_X, 0);
      check("desc1_x", form_x, 168);
      tick();
      check("desc1_one_cycle", enemy_direction_Y, 0);
      check("desc1_pulse_width", step_pulse, 0);
      wait_move(0, 100, n);
      check("left_step_frame", n, 30);
      check("left_step_x", form_x, 164);

      // Keep sweeping until the 12th descent lands the formation.
      for (int k = 2; k <= 12; k++) begin
         wait_move(1, 2500, n);
         check("descent_found", int'(n > 0), 1);
         check("descent_y", form_y, 40 + 16 * k);
         check("descent_x", form_x, (k % 2 == 1) ? 168 : 0);
         if (n < 0) break;
      end
      check("desc12_not_landed_yet", landed, 0);
      tick();
      check("landed", landed, 1);
      count_pulses(100, c);
      check("landed_no_pulse", c, 0);
      check("landed_hold_y", form_y, 232);
      check("landed_terminal", landed, 1);

      // Single left column: descent only once form_x+54 exceeds 640.
      do_reset();
      check("rst2_landed", landed, 0);
      col_alive = 8'b0000_0001;
      do_start();
      hsteps = 0;
      for (int s = 0; s < 200; s++) begin
         wait_move(0, 100, n);
         if (n < 0 || enemy_direction_Y) break;
         hsteps++;
      end
      check("col0_hsteps", hsteps, 127);
      check("col0_desc_dir_y", enemy_direction_Y, 1);
      check("col0_desc_x", form_x, 588);
      check("col0_desc_y", form_y, 56);

      // Pause for 10 frames at timer 15 delays the step by 10.
      do_reset();
      col_alive = 8'hFF;
      do_start();
      count_pulses(15, c);
      pause = 1'b1;
      count_pulses(10, c2);
      pause = 1'b0;
      check("pause_no_early", c + c2, 0);
      wait_move(0, 100, n);
      check("pause_delay", 25 + n, 40);
      check("pause_step_x", form_x, 84);
      count_pulses(29, c);
      check("due_count", c, 0);
      pause = 1'b1;
      count_pulses(3, c);
      check("pause_over_due", c, 0);
      check("pause_over_due_x", form_x, 84);
      pause = 1'b0;
      wait_move(0, 10, n);
      check("resume_due", n, 1);
      check("resume_x", form_x, 88);

      // All columns die exactly when a step is due.
      do_reset();
      do_start();
      count_pulses(29, c);
      col_alive = 8'h00;
      tick();
      check("clr_cleared", cleared, 1);
      check("clr_pulse", step_pulse, 0);
      check("clr_form_x", form_x, 80);
      col_alive = 8'hFF;
      count_pulses(40, c);
      check("clr_terminal_pulses", c, 0);
      check("clr_terminal", cleared, 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("clr_reset", cleared, 0);

      // Reset mid-march restores origin and IDLE.
      do_start();
      for (int s = 0; s < 3; s++) wait_move(0, 100, n);
      check("mid_x", form_x, 92);
      tick(10);
      Reset = 1'b1;
      start = 1'b1;
      tick();
      check("midrst_x", form_x, 80);
      check("midrst_y", form_y, 40);
      check("midrst_dir_x", enemy_direction_X, 1);
      check("midrst_pulse", step_pulse, 0);
      Reset = 1'b0;
      start = 1'b0;
      count_pulses(40, c);
      check("midrst_idle", c, 0);
      check("midrst_idle_x", form_x, 80);

      // Period source: enemies_left only matters with the speedup build.
      enemies_left = 6'd1;
      do_start();
`ifdef MARCH_SPEEDUP_EN
      wait_move(0, 100, n);
      check("speed_first", n, 2);
      wait_move(0, 100, n);
      check("speed_second", n, 2);
      check("speed_x", form_x, 88);
      enemies_left = 6'd5;
      tick();
      enemies_left = 6'd2;
      wait_move(0, 100, n);
      check("speed_latched", 1 + n, 5);
`else
      wait_move(0, 100, n);
      check("nospeed_period", n, 30);
      check("nospeed_x", form_x, 84);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
